// File: rtl/rans_dec.sv
// rtl/rans_dec.sv - streaming rANS decoder with host-written symbol and slot tables
module rans_dec #(
  parameter int RESOLUTION   = 10,
  parameter int SYMBOL_WIDTH = 8,
  parameter int COUNT_WIDTH  = 16
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  input  logic                             freq_wr_i,
  input  logic [SYMBOL_WIDTH-1:0]          freq_addr_i,
  input  logic [RESOLUTION-1:0]            freq_i,
  input  logic [RESOLUTION-1:0]            cum_freq_i,
  input  logic                             slot_wr_i,
  input  logic [RESOLUTION-1:0]            slot_addr_i,
  input  logic [SYMBOL_WIDTH-1:0]          slot_symb_i,
  input  logic                             start_i,
  input  logic [RESOLUTION+SYMBOL_WIDTH-1:0] init_state_i,
  input  logic [COUNT_WIDTH-1:0]           count_i,
  input  logic                             in_valid_i,
  input  logic [SYMBOL_WIDTH-1:0]          in_byte_i,
  output logic                             in_ready_o,
  output logic                             symb_valid_o,
  output logic [SYMBOL_WIDTH-1:0]          symb_o,
  input  logic                             symb_ready_i,
  output logic                             busy_o,
  output logic                             done_o,
  output logic                             err_o,
  output logic [RESOLUTION+SYMBOL_WIDTH-1:0] state_o
);

  localparam int XW = RESOLUTION + SYMBOL_WIDTH;
  localparam logic [XW-1:0] L_MIN = XW'(1) << RESOLUTION;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RENORM,
    ST_SLOT,
    ST_FREQ,
    ST_CALC,
    ST_OUT
  } state_t;

  state_t state_q, state_d;

  logic [SYMBOL_WIDTH-1:0] slot_mem [2**RESOLUTION];
  logic [RESOLUTION-1:0]   freq_mem [2**SYMBOL_WIDTH];
  logic [RESOLUTION-1:0]   cum_mem  [2**SYMBOL_WIDTH];

  logic [XW-1:0]           x_q;
  logic [COUNT_WIDTH-1:0]  cnt_q;
  logic                    err_q;
  logic [RESOLUTION-1:0]   slot_q;
  logic [SYMBOL_WIDTH-1:0] sym_q;
  logic [RESOLUTION-1:0]   f_q;
  logic [RESOLUTION-1:0]   c_q;

  logic                    x_low;
  logic [XW-1:0]           prod;
  logic [XW-1:0]           x_calc;
  logic                    calc_err;

  assign x_low  = (x_q < L_MIN);
  // x >> RESOLUTION fits in SYMBOL_WIDTH bits, so the product of two zero-extended operands fits in XW
  assign prod   = {{SYMBOL_WIDTH{1'b0}}, f_q} * {{RESOLUTION{1'b0}}, x_q[XW-1:RESOLUTION]};
  assign x_calc = prod + {{SYMBOL_WIDTH{1'b0}}, slot_q} - {{SYMBOL_WIDTH{1'b0}}, c_q};
  assign calc_err = (f_q == '0) || (slot_q < c_q) ||
                    ({1'b0, slot_q} >= ({1'b0, c_q} + {1'b0, f_q}));

  // Host writes to the symbol freq/cum table; no reset, contents survive rst_ni
  always_ff @(posedge clk_i) begin
    if (freq_wr_i) begin
      freq_mem[freq_addr_i] <= freq_i;
      cum_mem[freq_addr_i]  <= cum_freq_i;
    end
  end

  // Host writes to the slot-to-symbol table
  always_ff @(posedge clk_i) begin
    if (slot_wr_i) begin
      slot_mem[slot_addr_i] <= slot_symb_i;
    end
  end

  // Synchronous table reads: slot lookup in SLOT, freq/cum lookup in FREQ
  always_ff @(posedge clk_i) begin
    if (state_q == ST_SLOT) begin
      slot_q <= x_q[RESOLUTION-1:0];
      sym_q  <= slot_mem[x_q[RESOLUTION-1:0]];
    end
    if (state_q == ST_FREQ) begin
      f_q <= freq_mem[sym_q];
      c_q <= cum_mem[sym_q];
    end
  end

  // FSM state register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic and handshake outputs
  always_comb begin
    state_d      = state_q;
    in_ready_o   = 1'b0;
    symb_valid_o = 1'b0;
    done_o       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_i) state_d = ST_RENORM;
      end
      ST_RENORM: begin
        if (x_low) begin
          in_ready_o = 1'b1;
        end else if (cnt_q == '0) begin
          done_o  = 1'b1;
          state_d = ST_IDLE;
        end else begin
          state_d = ST_SLOT;
        end
      end
      ST_SLOT: state_d = ST_FREQ;
      ST_FREQ: state_d = ST_CALC;
      ST_CALC: state_d = ST_OUT;
      ST_OUT: begin
        symb_valid_o = 1'b1;
        if (symb_ready_i) state_d = ST_RENORM;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Decoder state x, remaining count and sticky error flag
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      x_q   <= L_MIN;
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start_i) begin
            x_q   <= init_state_i;
            cnt_q <= count_i;
            err_q <= 1'b0;
          end
        end
        ST_RENORM: begin
          // x < L_MIN here, so the shifted-out top bits are always zero
          if (x_low && in_valid_i) x_q <= {x_q[XW-SYMBOL_WIDTH-1:0], in_byte_i};
        end
        ST_CALC: begin
          x_q <= x_calc;
          if (calc_err) err_q <= 1'b1;
        end
        ST_OUT: begin
          if (symb_ready_i) cnt_q <= cnt_q - COUNT_WIDTH'(1);
        end
        default: ;
      endcase
    end
  end

  assign symb_o  = (state_q == ST_OUT) ? sym_q : '0;
  assign busy_o  = (state_q != ST_IDLE);
  assign err_o   = err_q;
  assign state_o = x_q;

endmodule
